lsu_port_arbiter: RTL
=====================

// Module: lsu_port_arbiter
// PURPOSE
// - Shares the single 16-bit LSU between two requesters: fetch port (F, read-only) and data port (D, read/write).
// - Selects one request per cycle and registers it into a one-entry issue slot that drives the LSU request interface.
// - Tracks outstanding requests per port and routes LSU writeback completions back to the owning port.
// - Sits between the fetch unit / load-store reservation station and lsu_16b.
// PARAMETERS
// - MAX_OUTST   2  max granted-but-not-completed requests per port (legal 1..3)
// - STARVE_MAX  7  cycles F may wait before forced priority (used only with LSU_ARB_AGE_EN)
// PORTS
// - clk          in   1   clock, all state on rising edge
// - a_rst        in   1   asynchronous active-low reset
// - f_req        in   1   fetch request valid
// - f_addr       in   16  fetch address
// - f_width      in   1   0: 16 bit, 1: 8 bit
// - f_tag        in   1   fetch sub-tag
// - f_gnt        out  1   fetch request accepted this cycle (combinational)
// - f_done       out  1   fetch completion pulse
// - f_done_tag   out  1   sub-tag of completed fetch
// - d_req        in   1   data request valid
// - d_addr       in   16  data address
// - d_data       in   16  write data
// - d_width      in   1   0: 16 bit, 1: 8 bit
// - d_cmd        in   1   0: read, 1: write
// - d_tag        in   1   data sub-tag
// - d_gnt        out  1   data request accepted this cycle (combinational)
// - d_done       out  1   data completion pulse
// - d_done_tag   out  1   sub-tag of completed data access
// - lsu_rq_addr  out  16  to LSU rq_addr
// - lsu_rq_data  out  16  to LSU rq_data
// - lsu_rq_width out  1   to LSU rq_width
// - lsu_rq_cmd   out  1   to LSU rq_cmd
// - lsu_rq_tag   out  2   {port, sub-tag}; port 0 = F, 1 = D
// - lsu_rq_start out  1   issue slot valid
// - lsu_rq_hold  in   1   LSU cannot accept
// - lsu_wb       in   1   LSU completion strobe
// - lsu_wb_tag   in   2   tag of completed request
// BEHAVIOUR
// - Reset: slot EMPTY, all lsu_rq_* = 0, f/d_done = 0, outstanding counters = 0.
// - Slot FSM: EMPTY -> FULL on grant; FULL -> EMPTY when lsu_rq_start & ~lsu_rq_hold and no new grant; FULL -> FULL on accept+grant.
// - lsu_rq_start = (state == FULL); slot fields stable while FULL and not accepted.
// - slot_free = EMPTY | (lsu_rq_start & ~lsu_rq_hold).
// - X_gnt = X_req & slot_free & (cnt_X < MAX_OUTST) & selected(X); at most one gnt per cycle.
// - Selection: D has priority over F when both eligible.
// - On grant the slot loads at the next edge; latency req -> lsu_rq_start = 1 cycle.
// - F grants force lsu_rq_cmd = 0, lsu_rq_data = 0; tag = {1'b0, f_tag}. D: tag = {1'b1, d_tag}.
// - Requester keeps req and fields stable until gnt; dropping req before gnt is legal, nothing is issued.
// - Completion: lsu_wb routes by lsu_wb_tag[1]; X_done = 1 for that cycle, X_done_tag = lsu_wb_tag[0]; combinational pass-through.
// - Every lsu_wb completes a request, read or write.
// - cnt_X: +1 on X_gnt, -1 on X completion, unchanged when both occur in the same cycle.
// - cnt_X saturates at 0: a completion with cnt_X == 0 is forwarded, counter stays 0.
// - Reset mid-operation clears slot and counters; in-flight requests produce no done pulse.
// CONFIGURATION
// - LSU_ARB_AGE_EN defined: starve counter (width clog2(STARVE_MAX+1)) +1 per cycle with f_req & ~f_gnt.
// - Counter clears on f_gnt or ~f_req; at >= STARVE_MAX, F has priority over D until F is granted.
// - LSU_ARB_AGE_EN undefined: strict D priority, no starve counter, STARVE_MAX unused.
// TESTING
// - F-only: f_req, f_addr=16'h1000, f_tag=1 -> f_gnt same cycle; next cycle lsu_rq_start=1, tag=2'b01, cmd=0.
// - Same-cycle F and D requests -> d_gnt=1, f_gnt=0; F granted the cycle the LSU accepts D.
// - lsu_rq_hold=1 for 3 cycles with slot FULL -> lsu_rq_* stable, no gnt; hold drops -> new grant same cycle.
// - D issues 2 requests, no wb -> d_gnt=0 at cnt_D=2; lsu_wb, tag=2'b11 -> d_done=1, d_done_tag=1, next D grantable.
// - wb and grant to F same cycle at cnt_F=1 -> cnt_F stays 1; a_rst low mid-FULL -> lsu_rq_start=0 asynchronously.
// - LSU_ARB_AGE_EN: d_req and f_req held high -> F granted after 7 waiting cycles despite D; undefined -> F never granted.

Source files
------------

// File: rtl/lsu_port_arbiter.sv
// Two-port (fetch/data) arbiter feeding the shared 16-bit LSU through a one-entry issue slot.
// Optional fetch anti-starvation aging is enabled with `define LSU_ARB_AGE_EN.
module lsu_port_arbiter #(
    parameter int MAX_OUTST  = 2,
    parameter int STARVE_MAX = 7
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    input  logic        f_width,
    input  logic        f_tag,
    output logic        f_gnt,
    output logic        f_done,
    output logic        f_done_tag,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data,
    input  logic        d_width,
    input  logic        d_cmd,
    input  logic        d_tag,
    output logic        d_gnt,
    output logic        d_done,
    output logic        d_done_tag,
    output logic [15:0] lsu_rq_addr,
    output logic [15:0] lsu_rq_data,
    output logic        lsu_rq_width,
    output logic        lsu_rq_cmd,
    output logic [1:0]  lsu_rq_tag,
    output logic        lsu_rq_start,
    input  logic        lsu_rq_hold,
    input  logic        lsu_wb,
    input  logic [1:0]  lsu_wb_tag
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;
    localparam logic [1:0] MAX_C   = 2'(MAX_OUTST);

    if (MAX_OUTST < 1 || MAX_OUTST > 3 || STARVE_MAX < 1) begin : g_bad_param
        $error("lsu_port_arbiter: illegal parameter value");
    end

    logic [0:0] state;
    logic [1:0] cnt_f;
    logic [1:0] cnt_d;
    logic       slot_free;
    logic       accept;
    logic       f_elig;
    logic       d_elig;
    logic       f_prio;
    logic       f_dec;
    logic       d_dec;

    assign lsu_rq_start = (state == S_FULL);
    assign accept       = lsu_rq_start & ~lsu_rq_hold;
    assign slot_free    = (state == S_EMPTY) | accept;

    assign f_elig = f_req & slot_free & (cnt_f < MAX_C);
    assign d_elig = d_req & slot_free & (cnt_d < MAX_C);

    // An aged fetch overrides data priority only while it is itself eligible.
    assign f_gnt = f_elig & (f_prio | ~d_elig);
    assign d_gnt = d_elig & ~(f_prio & f_elig);

    assign f_done     = lsu_wb & ~lsu_wb_tag[1];
    assign d_done     = lsu_wb & lsu_wb_tag[1];
    assign f_done_tag = lsu_wb_tag[0];
    assign d_done_tag = lsu_wb_tag[0];

    assign f_dec = f_done & (cnt_f != 2'd0);
    assign d_dec = d_done & (cnt_d != 2'd0);

`ifdef LSU_ARB_AGE_EN
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] S_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve;

    assign f_prio = (starve >= S_LIM);

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            starve <= '0;
        end else if (f_gnt || !f_req) begin
            starve <= '0;
        end else if (starve < S_LIM) begin
            starve <= starve + 1'b1;
        end
    end
`else
    assign f_prio = 1'b0;
`endif

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state        <= S_EMPTY;
            lsu_rq_addr  <= '0;
            lsu_rq_data  <= '0;
            lsu_rq_width <= 1'b0;
            lsu_rq_cmd   <= 1'b0;
            lsu_rq_tag   <= '0;
        end else if (d_gnt) begin
            state        <= S_FULL;
            lsu_rq_addr  <= d_addr;
            lsu_rq_data  <= d_data;
            lsu_rq_width <= d_width;
            lsu_rq_cmd   <= d_cmd;
            lsu_rq_tag   <= {1'b1, d_tag};
        end else if (f_gnt) begin
            state        <= S_FULL;
            lsu_rq_addr  <= f_addr;
            lsu_rq_data  <= '0;
            lsu_rq_width <= f_width;
            lsu_rq_cmd   <= 1'b0;
            lsu_rq_tag   <= {1'b0, f_tag};
        end else if (accept) begin
            state <= S_EMPTY;
        end
    end

    // Completions at a zero count are forwarded but never underflow the counter.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            cnt_f <= 2'd0;
            cnt_d <= 2'd0;
        end else begin
            if (f_gnt && !f_dec) begin
                cnt_f <= cnt_f + 2'd1;
            end else if (f_dec && !f_gnt) begin
                cnt_f <= cnt_f - 2'd1;
            end
            if (d_gnt && !d_dec) begin
                cnt_d <= cnt_d + 2'd1;
            end else if (d_dec && !d_gnt) begin
                cnt_d <= cnt_d - 2'd1;
            end
        end
    end

endmodule
